// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel ultrasonic ranger. Channels are served round-robin: trigger
// pulse, echo timing in microseconds, divider-free cm conversion, timeout flags.
module ultrasonic_ranger_mc #(
    parameter int CLK_HZ     = 27000000,
    parameter int N_CH       = 4,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_US  = 60000,
    parameter int TIMEOUT_US = 30000,
    parameter int US_PER_CM  = 58,
    parameter int DIST_W     = 10,
    parameter int CH_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [N_CH-1:0]        echo,
    output logic [N_CH-1:0]        trig,
    output logic [N_CH*DIST_W-1:0] dist_cm,
    output logic                   dist_valid,
    output logic [CH_W-1:0]        dist_ch,
    output logic [N_CH-1:0]        timeout,
    output logic                   busy
);
    localparam int DIV       = CLK_HZ / 1000000;
    localparam int TRIG_CLKS = TRIG_US * DIV;
    localparam int PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TRG_W     = $clog2(TRIG_CLKS + 1);
    localparam int PER_W     = $clog2(PERIOD_US + 1);
    localparam int US_W      = $clog2(TIMEOUT_US + 1);
    localparam int SUB_W     = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [TRG_W-1:0]  TRIG_LAST = TRG_W'(TRIG_CLKS - 1);
    localparam logic [PER_W-1:0]  PER_END   = PER_W'(PERIOD_US);
    localparam logic [PER_W-1:0]  PER_PRE   = PER_W'(PERIOD_US - 1);
    localparam logic [US_W-1:0]   US_END    = US_W'(TIMEOUT_US);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = '1;
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CH_W-1:0]     r_ch;
    logic [CH_W-1:0]     w_ch_next;
    logic [N_CH-1:0]     r_sync1;
    logic [N_CH-1:0]     r_sync2;
    logic [PRE_W-1:0]    r_pre;
    logic [TRG_W-1:0]    r_trig_cnt;
    logic [PER_W-1:0]    r_period;
    logic [US_W-1:0]     r_us;
    logic [SUB_W-1:0]    r_sub;
    logic [DIST_W-1:0]   r_cm;
    logic [N_CH-1:0]     r_trig;
    logic [N_CH*DIST_W-1:0] r_dist;
    logic                r_valid;
    logic [CH_W-1:0]     r_dist_ch;
    logic [N_CH-1:0]     r_timeout;

    logic                w_us_tick;
    logic                w_echo_sel;
    logic                w_us_expired;
    logic                w_period_done;
    logic                w_enter_trig;
    logic                w_enter_wait;
    logic                w_enter_meas;
    logic                w_done_ok;
    logic                w_done_to;
    logic [N_CH-1:0]     w_trig_next;
    logic [SUB_W-1:0]    w_sub_base;
    logic [SUB_W-1:0]    w_sub_next;
    logic [DIST_W-1:0]   w_cm_base;
    logic [DIST_W-1:0]   w_cm_next;

    assign w_us_tick     = (r_pre == PRE_LAST);
    assign w_us_expired  = (r_us == US_END);
    // Look one tick ahead so consecutive trigger starts are exactly PERIOD_US apart.
    assign w_period_done = (r_period == PER_END) || (w_us_tick && (r_period == PER_PRE));

    always_comb begin
        w_echo_sel = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_ch == CH_W'(k)) w_echo_sel = r_sync2[k];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_enter_trig = 1'b0;
        w_enter_wait = 1'b0;
        w_enter_meas = 1'b0;
        w_done_ok    = 1'b0;
        w_done_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_TRIG;
                    w_enter_trig = 1'b1;
                end
            end
            S_TRIG: begin
                if (r_trig_cnt == TRIG_LAST) begin
                    w_state_next = S_WAIT_RISE;
                    w_enter_wait = 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (w_echo_sel) begin
                    w_state_next = S_MEASURE;
                    w_enter_meas = 1'b1;
                end else if (w_us_expired) begin
                    w_state_next = S_GAP;
                    w_done_to    = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!w_echo_sel) begin
                    w_state_next = S_GAP;
                    w_done_ok    = 1'b1;
                end else if (w_us_expired) begin
                    w_state_next = S_GAP;
                    w_done_to    = 1'b1;
                end
            end
            S_GAP: begin
                if (w_period_done) begin
                    w_ch_next = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
                    if (enable) begin
                        w_state_next = S_TRIG;
                        w_enter_trig = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_trig_next = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_trig_next[k] = (w_state_next == S_TRIG) && (w_ch_next == CH_W'(k));
        end
    end

    // The tick in the rise-detect cycle is counted so W us of echo gives exactly W ticks.
    always_comb begin
        w_sub_base = w_enter_meas ? '0 : r_sub;
        w_cm_base  = w_enter_meas ? '0 : r_cm;
        w_sub_next = w_sub_base;
        w_cm_next  = w_cm_base;
        if (w_us_tick && (w_enter_meas || (r_state == S_MEASURE))) begin
            if (w_sub_base == SUB_LAST) begin
                w_sub_next = '0;
                if (w_cm_base != CM_MAX) w_cm_next = w_cm_base + 1'b1;
            end else begin
                w_sub_next = w_sub_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_pre      <= '0;
            r_trig_cnt <= '0;
            r_period   <= '0;
            r_us       <= '0;
            r_sub      <= '0;
            r_cm       <= '0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
            r_sync1 <= echo;
            r_sync2 <= r_sync1;
            r_sub   <= w_sub_next;
            r_cm    <= w_cm_next;

            if (w_enter_trig || w_us_tick) r_pre <= '0;
            else                           r_pre <= r_pre + 1'b1;

            if (w_enter_trig)              r_trig_cnt <= '0;
            else if (r_state == S_TRIG)    r_trig_cnt <= r_trig_cnt + 1'b1;

            if (w_enter_trig)                          r_period <= '0;
            else if (w_us_tick && r_period != PER_END) r_period <= r_period + 1'b1;

            if (w_enter_wait)                      r_us <= '0;
            else if (w_us_tick && r_us != US_END)  r_us <= r_us + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig    <= '0;
            r_dist    <= '0;
            r_valid   <= 1'b0;
            r_dist_ch <= '0;
            r_timeout <= '0;
        end else begin
            r_trig  <= w_trig_next;
            r_valid <= w_done_ok || w_done_to;
            if (w_done_ok || w_done_to) r_dist_ch <= r_ch;
            for (int k = 0; k < N_CH; k++) begin
                if (r_ch == CH_W'(k)) begin
                    if (w_done_ok) begin
                        r_dist[k*DIST_W +: DIST_W] <= r_cm;
                        r_timeout[k]               <= 1'b0;
                    end else if (w_done_to) begin
                        r_timeout[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign trig       = r_trig;
    assign dist_cm    = r_dist;
    assign dist_valid = r_valid;
    assign dist_ch    = r_dist_ch;
    assign timeout    = r_timeout;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Directed bench for ultrasonic_ranger_mc: 2 channels at 1 MHz so one clock
// equals one microsecond; relative cycle 1 is the first cycle trig is high.
module tb_ultrasonic_ranger_mc;
    localparam int CLK_HZ     = 1000000;
    localparam int N_CH       = 2;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_US  = 2000;
    localparam int TIMEOUT_US = 1000;
    localparam int US_PER_CM  = 58;
    localparam int DIST_W     = 10;
    localparam int CH_W       = 4;

    logic                   clk    = 1'b0;
    logic                   rst    = 1'b1;
    logic                   enable = 1'b0;
    logic [N_CH-1:0]        echo   = '0;
    logic [N_CH-1:0]        trig;
    logic [N_CH*DIST_W-1:0] dist_cm;
    logic                   dist_valid;
    logic [CH_W-1:0]        dist_ch;
    logic [N_CH-1:0]        timeout;
    logic                   busy;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int prev_start = 0;

    ultrasonic_ranger_mc #(
        .CLK_HZ(CLK_HZ), .N_CH(N_CH), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US), .US_PER_CM(US_PER_CM), .DIST_W(DIST_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
        .dist_cm(dist_cm), .dist_valid(dist_valid), .dist_ch(dist_ch),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DIST_W-1:0] dist_of(input int ch);
        return dist_cm[ch*DIST_W +: DIST_W];
    endfunction

    task automatic at_rel(input int t0, input int n);
        while (cyc < t0 + n - 1) @(negedge clk);
    endtask

    task automatic wait_trig(input int ch, output int t0);
        int n = 0;
        while (trig[ch] !== 1'b1 && n < 2500) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        checks++;
        if (trig[ch] !== 1'b1) begin
            errors++;
            $display("FAIL trig_start ch%0d: trig=%b, required trig[%0d]=1 within 2500 cycles", ch, trig, ch);
        end
    endtask

    task automatic drive_echo(input int ch, input int t0, input int rise_rel, input int fall_rel);
        at_rel(t0, rise_rel);
        echo[ch] = 1'b1;
        at_rel(t0, fall_rel);
        echo[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; echo = '0;
        repeat (4) @(negedge clk);
        checks++; if (trig !== '0) begin errors++; $display("FAIL reset_trig: got %b want 0", trig); end
        checks++; if (dist_cm !== '0) begin errors++; $display("FAIL reset_dist: got %h want 0", dist_cm); end
        checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dist_valid); end
        checks++; if (dist_ch !== '0) begin errors++; $display("FAIL reset_ch: got %0d want 0", dist_ch); end
        checks++; if (timeout !== '0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_first_channel();
        int t0, trel, hi;
        logic other;
        trel = cyc;
        enable = 1'b1;
        rst = 1'b0;
        wait_trig(0, t0);
        checks++; if (t0 != trel + 1) begin errors++; $display("FAIL first_trig_latency: got %0d want %0d", t0 - trel, 1); end
        checks++; if (trig !== 2'b01) begin errors++; $display("FAIL first_trig_onehot: got %b want 01", trig); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b want 1", busy); end
        hi = 0; other = 1'b0;
        while (trig[0] === 1'b1 && hi < 20) begin
            hi++;
            if (trig[1] !== 1'b0) other = 1'b1;
            @(negedge clk);
        end
        checks++; if (hi != 10) begin errors++; $display("FAIL trig_width: got %0d want 10", hi); end
        checks++; if (other) begin errors++; $display("FAIL trig1_quiet: got 1 want 0"); end
        drive_echo(0, t0, 61, 641);
        at_rel(t0, 643);
        checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b want 0", dist_valid); end
        at_rel(t0, 644);
        checks++; if (dist_valid !== 1'b1 || dist_ch !== 4'd0) begin errors++; $display("FAIL valid_580: got valid=%b ch=%0d want valid=1 ch=0", dist_valid, dist_ch); end
        checks++; if (dist_of(0) !== 10'd10) begin errors++; $display("FAIL dist_580: got %0d want 10", dist_of(0)); end
        checks++; if (timeout[0] !== 1'b0) begin errors++; $display("FAIL timeout_580: got %b want 0", timeout[0]); end
        at_rel(t0, 645);
        checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL valid_single: got %b want 0", dist_valid); end
        prev_start = t0;
    endtask

    task automatic test_boundary_widths();
        int chs[3] = '{1, 0, 1};
        int wid[3] = '{58, 57, 115};
        int exp_cm[3] = '{1, 0, 1};
        int t0;
        for (int i = 0; i < 3; i++) begin
            wait_trig(chs[i], t0);
            checks++; if (t0 - prev_start != 2000) begin errors++; $display("FAIL period_%0d: got %0d want 2000", i, t0 - prev_start); end
            drive_echo(chs[i], t0, 61, 61 + wid[i]);
            at_rel(t0, 61 + wid[i] + 3);
            checks++; if (dist_valid !== 1'b1 || dist_ch !== CH_W'(chs[i])) begin errors++; $display("FAIL valid_w%0d: got valid=%b ch=%0d want valid=1 ch=%0d", wid[i], dist_valid, dist_ch, chs[i]); end
            checks++; if (dist_of(chs[i]) !== DIST_W'(exp_cm[i])) begin errors++; $display("FAIL dist_w%0d: got %0d want %0d", wid[i], dist_of(chs[i]), exp_cm[i]); end
            prev_start = t0;
        end
    endtask

    task automatic test_timeout_race();
        int t0;
        // Echo low seen by the FSM in the very cycle the timeout is reached.
        wait_trig(0, t0);
        checks++; if (t0 - prev_start != 2000) begin errors++; $display("FAIL period_race: got %0d want 2000", t0 - prev_start); end
        drive_echo(0, t0, 61, 1009);
        at_rel(t0, 1011);
        checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL race_early: got %b want 0", dist_valid); end
        at_rel(t0, 1012);
        checks++; if (dist_valid !== 1'b1) begin errors++; $display("FAIL race_valid: got %b want 1", dist_valid); end
        checks++; if (dist_of(0) !== 10'd16) begin errors++; $display("FAIL race_dist: got %0d want 16", dist_of(0)); end
        checks++; if (timeout[0] !== 1'b0) begin errors++; $display("FAIL race_timeout: got %b want 0", timeout[0]); end
        prev_start = t0;

        // Channel 1 never echoes while channel 0 is held high.
        wait_trig(1, t0);
        echo[0] = 1'b1;
        at_rel(t0, 1011);
        checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL lost_early: got %b want 0", dist_valid); end
        at_rel(t0, 1012);
        checks++; if (dist_valid !== 1'b1 || dist_ch !== 4'd1) begin errors++; $display("FAIL lost_valid: got valid=%b ch=%0d want valid=1 ch=1", dist_valid, dist_ch); end
        checks++; if (timeout[1] !== 1'b1) begin errors++; $display("FAIL lost_flag: got %b want 1", timeout[1]); end
        checks++; if (dist_of(1) !== 10'd1) begin errors++; $display("FAIL lost_keep: got %0d want 1", dist_of(1)); end
        echo[0] = 1'b0;
        prev_start = t0;

        // One cycle later than the race: timeout wins.
        wait_trig(0, t0);
        checks++; if (trig !== 2'b01) begin errors++; $display("FAIL wrap_ch: got %b want 01", trig); end
        drive_echo(0, t0, 61, 1010);
        at_rel(t0, 1012);
        checks++; if (dist_valid !== 1'b1 || dist_ch !== 4'd0) begin errors++; $display("FAIL late_valid: got valid=%b ch=%0d want valid=1 ch=0", dist_valid, dist_ch); end
        checks++; if (timeout[0] !== 1'b1) begin errors++; $display("FAIL late_flag: got %b want 1", timeout[0]); end
        checks++; if (dist_of(0) !== 10'd16) begin errors++; $display("FAIL late_keep: got %0d want 16", dist_of(0)); end
        prev_start = t0;
    endtask

    task automatic test_enable_drop();
        int t0;
        logic bad;
        wait_trig(1, t0);
        at_rel(t0, 61);
        echo[1] = 1'b1;
        at_rel(t0, 300);
        enable = 1'b0;
        at_rel(t0, 641);
        echo[1] = 1'b0;
        at_rel(t0, 644);
        checks++; if (dist_valid !== 1'b1 || dist_ch !== 4'd1) begin errors++; $display("FAIL drop_valid: got valid=%b ch=%0d want valid=1 ch=1", dist_valid, dist_ch); end
        checks++; if (dist_of(1) !== 10'd10) begin errors++; $display("FAIL drop_dist: got %0d want 10", dist_of(1)); end
        checks++; if (timeout[1] !== 1'b0) begin errors++; $display("FAIL drop_flag_clear: got %b want 0", timeout[1]); end
        at_rel(t0, 2000);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b want 1", busy); end
        at_rel(t0, 2001);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        bad = 1'b0;
        for (int n = 2001; n <= 2100; n++) begin
            at_rel(t0, n);
            if (trig !== '0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL idle_quiet: got activity want trig=0 busy=0"); end
        enable = 1'b1;
        at_rel(t0, 2101);
        checks++; if (trig !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL restart: got trig=%b busy=%b want trig=01 busy=1", trig, busy); end
    endtask

    task automatic test_reset_mid_measure();
        int t0;
        wait_trig(0, t0);
        at_rel(t0, 61);
        echo[0] = 1'b1;
        at_rel(t0, 200);
        rst = 1'b1;
        at_rel(t0, 201);
        checks++;
        if ({trig, dist_cm, dist_valid, dist_ch, timeout, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got trig=%b dist=%h valid=%b ch=%0d to=%b busy=%b want all 0",
                     trig, dist_cm, dist_valid, dist_ch, timeout, busy);
        end
        echo[0] = 1'b0;
        at_rel(t0, 203);
        rst = 1'b0;
        at_rel(t0, 204);
        checks++; if (trig !== 2'b01 || dist_valid !== 1'b0) begin errors++; $display("FAIL post_reset: got trig=%b valid=%b want trig=01 valid=0", trig, dist_valid); end
    endtask

    initial begin
        test_reset();
        test_first_channel();
        test_boundary_widths();
        test_timeout_race();
        test_enable_drop();
        test_reset_mid_measure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded 70000 cycles");
        $fatal(1);
    end

endmodule
